// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-slot TDM receive path.
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;
endpackage

// File: rtl/tdm_demux4_demux1_4.sv
// Slot select to one-hot write enable; combinational, zero latency, no backpressure.
module demux1_4
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]    sel,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/tdm_demux4.sv
// 1:4 TDM demultiplexer with frame lock and per-frame snapshot; 1-cycle latency.
// No backpressure: every valid word is consumed in the cycle it arrives.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  input  logic                     sync,
  output logic [4*WIDTH-1:0]       lane,
  output logic [3:0]               lane_valid,
  output logic [4*WIDTH-1:0]       frame,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err
);
  tdm_state_t          state_q, state_d;
  logic [SLOT_W-1:0]   cnt_q, cnt_d;
  logic [4*WIDTH-1:0]  lane_q, lane_d;
  logic [4*WIDTH-1:0]  frame_q, frame_d;
  logic [3:0]          lane_valid_q, lane_valid_d;
  logic                frame_valid_q, frame_valid_d;
  logic                sync_err_q, sync_err_d;
  logic                wr_en;
  logic [SLOT_W-1:0]   wr_sel;
  logic [NUM_SLOTS-1:0] wr_we;

  demux1_4 u_demux (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (wr_we)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    wr_en         = 1'b0;
    wr_sel        = '0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (sync) begin
          wr_en   = 1'b1;
          cnt_d   = 2'd1;
          state_d = LOCKED;
        end
      end else if (sync) begin
        // Early sync abandons the partial frame and restarts at slot 0.
        sync_err_d = (cnt_q != 2'd0);
        wr_en      = 1'b1;
        cnt_d      = 2'd1;
      end else if (cnt_q != 2'd0) begin
        wr_en  = 1'b1;
        wr_sel = cnt_q;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          frame_d       = {din, lane_q[3*WIDTH-1:0]};
          frame_valid_d = 1'b1;
        end
      end else begin
        sync_err_d = 1'b1;
        state_d    = HUNT;
      end
    end
  end

  always_comb begin
    lane_d = lane_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (wr_we[k]) lane_d[k*WIDTH +: WIDTH] = din;
    end
    lane_valid_d = wr_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      cnt_q         <= '0;
      lane_q        <= '0;
      frame_q       <= '0;
      lane_valid_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lane_q        <= lane_d;
      frame_q       <= frame_d;
      lane_valid_q  <= lane_valid_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign lane        = lane_q;
  assign lane_valid  = lane_valid_q;
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
endmodule
